// File: rtl/mem_a_loader_if.sv
// Row input channel of the A-matrix loader.
// The producer (master) offers one signed A row per transfer; the loader
// (slave) takes it when valid and ready are both high at a rising edge.
interface mem_a_loader_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [BITS_AB-1:0] in_row [DIM-1:0];

  modport master (
    output in_valid,
    output in_row,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_row,
    output in_ready
  );
endinterface

// File: rtl/mem_a_loader.sv
// A-matrix loader: collects DIM signed rows over a valid/ready channel,
// writes each one into the skew buffer (Ain/Arow/WrEn), then on go holds
// the buffer shift enable for 2*DIM-1 cycles so every row, including the
// full skew, is pushed into the systolic array. Pulses done at the end.
module mem_a_loader #(
  parameter  int BITS_AB = 8,
  parameter  int DIM     = 8,
  localparam int ROW_W   = $clog2(DIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mem_a_loader_if.slave             in_if,
  input  logic                      go,
  input  logic                      clr,
  output logic signed [BITS_AB-1:0] Ain [DIM-1:0],
  output logic [ROW_W-1:0]          Arow,
  output logic                      WrEn,
  output logic                      en,
  output logic                      busy,
  output logic                      done
);

  // Stream counter must reach 2*DIM-2.
  localparam int STRM_W = $clog2(2 * DIM);

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIM - 1);
  localparam logic [STRM_W-1:0] STRM_LAST = STRM_W'(2 * DIM - 2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_LOADED = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  logic [1:0]        state_reg;
  logic [ROW_W-1:0]  row_cnt_reg;
  logic [STRM_W-1:0] strm_cnt_reg;
  logic              in_ready_int;
  logic              accept;
  logic              last_row;
  logic              strm_last;

  // Rows are only taken while collecting a matrix; LOADED/STREAM ignore in_valid.
  assign in_ready_int   = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
  assign in_if.in_ready = in_ready_int;
  assign accept         = in_if.in_valid & in_ready_int;
  assign last_row       = (row_cnt_reg == ROW_LAST);
  assign strm_last      = (strm_cnt_reg == STRM_LAST);
  assign busy           = (state_reg != ST_IDLE);

  // Sequencer state and row/stream counters; clr beats accept and go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      row_cnt_reg  <= '0;
      strm_cnt_reg <= '0;
    end else if (clr) begin
      state_reg    <= ST_IDLE;
      row_cnt_reg  <= '0;
      strm_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_LOAD: begin
          // DIM >= 2, so the first accept from IDLE can never be the last row.
          if (accept) begin
            if (last_row) begin
              row_cnt_reg <= '0;
              state_reg   <= ST_LOADED;
            end else begin
              row_cnt_reg <= row_cnt_reg + ROW_W'(1);
              state_reg   <= ST_LOAD;
            end
          end
        end
        ST_LOADED: begin
          if (go) begin
            strm_cnt_reg <= '0;
            state_reg    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (strm_last) begin
            strm_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
          end else begin
            strm_cnt_reg <= strm_cnt_reg + STRM_W'(1);
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          row_cnt_reg  <= '0;
          strm_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Write strobe: one cycle after each accepted row, never held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WrEn <= 1'b0;
    end else if (clr) begin
      WrEn <= 1'b0;
    end else begin
      WrEn <= accept;
    end
  end

  // Row index and row data follow each accept; they hold otherwise (also on clr).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Arow <= '0;
      for (int c = 0; c < DIM; c++) begin
        Ain[c] <= '0;
      end
    end else if (accept && !clr) begin
      Arow <= row_cnt_reg;
      for (int c = 0; c < DIM; c++) begin
        Ain[c] <= in_if.in_row[c];
      end
    end
  end

  // Shift enable rises on go in LOADED and falls with a one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en   <= 1'b0;
      done <= 1'b0;
    end else if (clr) begin
      en   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg == ST_LOADED && go) begin
        en <= 1'b1;
      end else if (state_reg == ST_STREAM && strm_last) begin
        en   <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_a_loader.sv
// Directed bench for mem_a_loader (DIM=8, BITS_AB=8).
module tb_mem_a_loader;
  localparam int BITS_AB = 8;
  localparam int DIM     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic go    = 1'b0;
  logic clr   = 1'b0;
  logic signed [BITS_AB-1:0] Ain [DIM-1:0];
  logic [2:0] Arow;
  logic WrEn, en, busy, done;

  mem_a_loader_if #(.BITS_AB(BITS_AB), .DIM(DIM)) in_if ();

  mem_a_loader #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (in_if),
    .go    (go),
    .clr   (clr),
    .Ain   (Ain),
    .Arow  (Arow),
    .WrEn  (WrEn),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  logic [63:0] ain_flat;
  always_comb begin
    ain_flat = '0;
    for (int c = 0; c < DIM; c++) ain_flat[c*8 +: 8] = Ain[c];
  end

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row r, column c: variant 0 is r*8+c with -128 at row 5 column 0.
  function automatic logic [7:0] elem(input int r, input int c, input int variant);
    logic [7:0] v;
    v = 8'(r * 8 + c);
    if (variant == 0 && r == 5 && c == 0) v = 8'h80;
    if (variant != 0) v = v ^ 8'hA5;
    return v;
  endfunction

  function automatic logic [63:0] row_flat(input int r, input int variant);
    logic [63:0] f;
    f = '0;
    for (int c = 0; c < DIM; c++) f[c*8 +: 8] = elem(r, c, variant);
    return f;
  endfunction

  // Load one full matrix; gapped uses the valid pattern 1,0,1,1,0,...
  // go is pulsed in cycle go_at (during loading, so it must be ignored).
  task automatic load_matrix(input bit gapped, input int variant, input int go_at);
    int r;
    int idx;
    bit v;
    r = 0;
    idx = 0;
    while (r < DIM && idx < 64) begin
      v = gapped ? !((idx % 5) == 1 || (idx % 5) == 4) : 1'b1;
      in_if.in_valid = v;
      for (int c = 0; c < DIM; c++) in_if.in_row[c] = elem(r, c, variant);
      go = (idx == go_at);
      check("in_ready_load", 64'(in_if.in_ready), 64'd1);
      tick();
      check("en_in_load", 64'(en), 64'd0);
      if (v) begin
        check("wren_accept", 64'(WrEn), 64'd1);
        check("arow", 64'(Arow), 64'(r));
        check("ain_row", ain_flat, row_flat(r, variant));
        r++;
      end else begin
        check("wren_gap", 64'(WrEn), 64'd0);
      end
      idx++;
    end
    in_if.in_valid = 1'b0;
    go = 1'b0;
    if (r != DIM) check("load_timeout", 64'(r), 64'(DIM));
    check("in_ready_loaded", 64'(in_if.in_ready), 64'd0);
    check("busy_loaded", 64'(busy), 64'd1);
    // in_valid in LOADED must not write.
    in_if.in_valid = 1'b1;
    for (int c = 0; c < DIM; c++) in_if.in_row[c] = 8'h11;
    repeat (3) begin
      tick();
      check("wren_loaded", 64'(WrEn), 64'd0);
      check("arow_loaded", 64'(Arow), 64'd7);
      check("ain_loaded", ain_flat, row_flat(DIM - 1, variant));
    end
    in_if.in_valid = 1'b0;
  endtask

  task automatic stream_full();
    int n;
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (en && n < 40) begin
      check("wren_in_stream", 64'(WrEn), 64'd0);
      check("done_in_stream", 64'(done), 64'd0);
      n++;
      tick();
    end
    check("en_cycles", 64'(n), 64'd15);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("in_ready_at_done", 64'(in_if.in_ready), 64'd1);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("en_after_done", 64'(en), 64'd0);
  endtask

  initial begin
    int n;
    in_if.in_valid = 1'b0;
    for (int c = 0; c < DIM; c++) in_if.in_row[c] = '0;

    // 1. Reset asserted mid-cycle takes effect immediately.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ain", ain_flat, 64'd0);
    check("rst_arow", 64'(Arow), 64'd0);
    check("rst_wren", 64'(WrEn), 64'd0);
    check("rst_en", 64'(en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    #20 rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_if.in_ready), 64'd1);

    // 2. Back-to-back load with go during LOAD (ignored); 4. full stream.
    load_matrix(1'b0, 0, 3);
    check("en_after_ignored_go", 64'(en), 64'd0);
    stream_full();

    // 3. Gapped load, then stream.
    load_matrix(1'b1, 1, -1);
    stream_full();

    // 5. Abort with clr in the 5th enable cycle.
    load_matrix(1'b0, 0, -1);
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (en && n < 4) begin
      n++;
      tick();
    end
    check("abort_en5", 64'(en), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_en", 64'(en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_arow_hold", 64'(Arow), 64'd7);
    repeat (20) begin
      tick();
      check("abort_no_done", 64'(done), 64'd0);
    end
    load_matrix(1'b0, 1, -1);
    stream_full();

    // 6. Reset after three accepted rows.
    in_if.in_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < DIM; c++) in_if.in_row[c] = elem(r, c, 0);
      tick();
    end
    in_if.in_valid = 1'b0;
    check("pre_rst_wren", 64'(WrEn), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ain", ain_flat, 64'd0);
    check("mid_rst_arow", 64'(Arow), 64'd0);
    check("mid_rst_wren", 64'(WrEn), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check("mid_rst_in_ready", 64'(in_if.in_ready), 64'd1);
    load_matrix(1'b0, 0, -1);
    stream_full();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
